// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_ALU   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_RS1 = 1'b1;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic PCSRC_ALU = 1'b0;
    localparam logic PCSRC_TGT = 1'b1;

    // States that wait on mem_ready and are guarded by the timeout counter.
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access is left pending; flags expiry on
// the cycle the count would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (count_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the expiring cycle clears instead of counting, so it wins.
    assign expired_o = count_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/memory/
// writeback, raises sticky illegal/mem_err faults and counts retired instructions.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 2,
    parameter int TIMEOUT  = 15,
    parameter int EN_JAL   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          mem_to_reg,
    output logic                pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                mem_err,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          dbg_state
);

    logic [3:0]       state_q, state_d;
    logic             is_store_q, is_store_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             waiting;
    logic             timeout;
    logic [1:0]       alu_op_raw;

    assign waiting = is_wait_state(state_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!waiting || mem_ready),
        .count_i   (waiting && !mem_ready),
        .expired_o (timeout)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_d  = illegal_q;
        mem_err_d  = mem_err_q;
        retired_d  = retired_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d   = ST_TRAP;
                    mem_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                is_store_d = (opcode == OP_STORE);
                case (opcode)
                    OP_R:                state_d = ST_EXEC_R;
                    OP_I:                state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE:   state_d = ST_MEM_ADDR;
                    OP_BRANCH:           state_d = ST_BRANCH;
                    OP_JAL: begin
                        if (EN_JAL != 0) begin
                            state_d = ST_JAL;
                        end else begin
                            state_d   = ST_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end else if (timeout) begin
                    state_d   = ST_TRAP;
                    mem_err_d = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d   = ST_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end else if (timeout) begin
                    state_d   = ST_TRAP;
                    mem_err_d = 1'b1;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: begin
                state_d   = ST_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            mem_err_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            mem_err_q  <= mem_err_d;
            retired_q  <= retired_d;
        end
    end

    // Moore decode; only the fetch/branch strobes look at mem_ready/zero.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        mem_to_reg = WB_SEL_ALU;
        pc_src     = PCSRC_ALU;
        alu_op_raw = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a  = SRCA_RS1;
                alu_op_raw = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op_raw = ALU_FUNCT;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: mem_read = 1'b1;
            ST_MEM_WR: mem_write = 1'b1;
            ST_WB_ALU: reg_write = 1'b1;
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_SEL_MEM;
            end
            ST_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op_raw = ALU_SUB;
                pc_src     = PCSRC_TGT;
                pc_write   = zero;
            end
            ST_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_SEL_PC4;
                pc_src     = PCSRC_TGT;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_op    = ALU_OP_W'(alu_op_raw);
    assign illegal   = illegal_q;
    assign mem_err   = mem_err_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 2, meaning alu_op width (>=2; upper bits zero).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max wait cycles for mem_ready (1..255).
REQ-003 SHALL have parameter EN_JAL, default 1, meaning JAL (7'b1101111) supported; 0 makes it illegal.
REQ-004 SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 opcode  in  7  instruction opcode from instruction register, valid from DECODE onward.
REQ-008 mem_ready  in  1  memory completed current access this cycle.
REQ-009 zero  in  1  ALU zero flag, used in BRANCH.
REQ-010 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-011 alu_src_a  out  1  0=PC, 1=rs1; alu_src_b  out  2  00=rs2, 01=const 4, 10=immediate.
REQ-012 mem_to_reg  out  2  00=ALU, 01=memory, 10=PC+4; pc_src  out  1  0=ALU result, 1=branch/jump target.
REQ-013 alu_op  out  ALU_OP_W  00=add, 01=sub/compare, 10=funct-decoded.
REQ-014 illegal, mem_err  out  1 each  sticky fault flags; retired  out  CNT_W  instructions completed.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP; all outputs Moore-decoded from state except those gated by mem_ready/zero below.
REQ-016 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00; when mem_ready=1, ir_write=1 and pc_write=1 in that cycle, next DECODE; else stay.
REQ-017 DECODE (one cycle): 0110011->EXEC_R; 0010011->EXEC_I; 0000011 or 0100011->MEM_ADDR; 1100011->BRANCH; 1101111->JAL if EN_JAL=1; any other opcode->TRAP with illegal set.
REQ-018 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU; EXEC_I: same with alu_src_b=10 -> WB_ALU.
REQ-019 WB_ALU: reg_write=1, mem_to_reg=00 -> FETCH.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; load->MEM_RD, store->MEM_WR (opcode captured in DECODE, not re-sampled).
REQ-021 MEM_RD: mem_read=1 until mem_ready, then WB_MEM; WB_MEM: reg_write=1, mem_to_reg=01 -> FETCH.
REQ-022 MEM_WR: mem_write=1 until mem_ready, then FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero -> FETCH.
REQ-024 JAL: reg_write=1, mem_to_reg=10, pc_src=1, pc_write=1 -> FETCH.
REQ-025 Wait counter SHALL clear on entering FETCH/MEM_RD/MEM_WR, increment each cycle mem_ready=0; reaching TIMEOUT without mem_ready -> TRAP, mem_err=1; mem_ready in the same cycle as the count reaching TIMEOUT wins (normal completion).
REQ-026 TRAP SHALL hold all strobes 0 and remain until reset; illegal/mem_err never clear except by reset.
REQ-027 retired SHALL increment by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JAL; wraps modulo 2^CNT_W.
REQ-028 Outputs not named for a state SHALL be 0 in that state; no two of mem_read/mem_write asserted together.

Reset
REQ-029 Reset SHALL force state FETCH, wait counter 0, retired 0, illegal 0, mem_err 0, immediately and independent of clk.
REQ-030 Reset asserted mid-instruction SHALL abandon it without any retired increment; first edge after deassertion begins FETCH.

Structure
REQ-031 Opcode constants, state encoding, alu_op and mux-select encodings SHALL live in shared package rv_ctrl_pkg.
REQ-032 Wait counter SHALL be sub-module mem_wait_timer (clear, count, expired outputs).

Verification
REQ-033 R-type 0110011, mem_ready=1 in FETCH: FETCH,DECODE,EXEC_R,WB_ALU,FETCH; reg_write=1 only in WB_ALU; retired 0->1.
REQ-034 Load 0000011, mem_ready delayed 3 cycles in MEM_RD: mem_read held 4 cycles, WB_MEM mem_to_reg=01, retired+1.
REQ-035 Branch 1100011: zero=1 -> pc_write=1, pc_src=1; zero=0 -> pc_write=0; both retire.
REQ-036 Opcode 7'b1111111 (and JAL with EN_JAL=0): TRAP, illegal=1, all strobes 0 for 20 cycles, clears only on reset.
REQ-037 mem_ready held 0 in FETCH with TIMEOUT=15: TRAP after 15 cycles, mem_err=1; mem_ready on cycle 15 completes fetch instead.
REQ-038 Reset pulsed during MEM_WR: state FETCH asynchronously, mem_write drops before next edge, retired unchanged at 0.
